// File: rtl/cr_kme_stall_fifo.sv
// cr_kme_stall_fifo: parametrised first-word-fall-through stall FIFO
//   clk, rst                    clock, async active-high reset
//   fifo_in/_valid/_stall       write data, request, advisory back-pressure
//   fifo_in_stall_override      forces stall low when OVERRIDE_EN=1
//   fifo_out/_valid/_ack        head entry, not-empty, consumer pop
//   fifo_clear                  synchronous flush of pointers, count, sticky flags
//   fifo_used/free_slots        occupancy
//   fifo_overflow/underflow     one-cycle pulses on dropped write / empty ack
//   fifo_err_sticky             {underflow_seen, overflow_seen}
module cr_kme_stall_fifo #(
   parameter int DATA_SIZE   = 132,
   parameter int FIFO_DEPTH  = 16,
   parameter int STALL_AT    = 0,
   parameter int OVERRIDE_EN = 0,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] fifo_in,
   input  logic                 fifo_in_valid,
   output logic                 fifo_in_stall,
   input  logic                 fifo_in_stall_override,
   output logic [DATA_SIZE-1:0] fifo_out,
   output logic                 fifo_out_valid,
   input  logic                 fifo_out_ack,
   input  logic                 fifo_clear,
   output logic [CNT_W-1:0]     fifo_used_slots,
   output logic [CNT_W-1:0]     fifo_free_slots,
   output logic                 fifo_overflow,
   output logic                 fifo_underflow,
   output logic [1:0]           fifo_err_sticky
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);
   logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic full, empty, pop, push, ovf, unf;
   assign full  = cnt == CNT_W'(FIFO_DEPTH);
   assign empty = cnt == '0;
   assign pop   = fifo_out_ack & ~empty;
   // a write into a full FIFO still lands when the head leaves in the same cycle
   assign push  = fifo_in_valid & (~full | pop);
   assign ovf   = fifo_in_valid & full & ~pop & ~fifo_clear;
   assign unf   = fifo_out_ack & empty & ~fifo_clear;
   assign fifo_out        = mem[rd_ptr];
   assign fifo_out_valid  = ~empty;
   assign fifo_used_slots = cnt;
   assign fifo_free_slots = CNT_W'(FIFO_DEPTH) - cnt;
   assign fifo_in_stall   = (fifo_free_slots <= CNT_W'(STALL_AT)) & ~((OVERRIDE_EN != 0) & fifo_in_stall_override);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         cnt             <= '0;
         fifo_overflow   <= 1'b0;
         fifo_underflow  <= 1'b0;
         fifo_err_sticky <= 2'b00;
      end else begin
         fifo_overflow  <= ovf;
         fifo_underflow <= unf;
         if (fifo_clear) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            cnt             <= '0;
            fifo_err_sticky <= 2'b00;
         end else begin
            if (push) mem[wr_ptr] <= fifo_in;
            if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            cnt             <= cnt + CNT_W'(push) - CNT_W'(pop);
            fifo_err_sticky <= fifo_err_sticky | {unf, ovf};
         end
      end
   end
endmodule

// File: tb/tb_cr_kme_stall_fifo.sv
// tb_cr_kme_stall_fifo: directed self-checking bench for two FIFO configurations
module tb_cr_kme_stall_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [131:0] a_in = '0, a_out;
   logic a_valid = 0, a_stall, a_ovr = 0, a_ovalid, a_ack = 0, a_clear = 0, a_of, a_uf;
   logic [4:0] a_used, a_free;
   logic [1:0] a_sticky;

   logic [15:0] b_in = '0, b_out;
   logic b_valid = 0, b_stall, b_ovr = 0, b_ovalid, b_ack = 0, b_clear = 0, b_of, b_uf;
   logic [2:0] b_used, b_free;
   logic [1:0] b_sticky;

   int passed = 0, total = 0;
   logic [15:0] q[$];

   cr_kme_stall_fifo dut_a (
      .clk(clk), .rst(rst), .fifo_in(a_in), .fifo_in_valid(a_valid), .fifo_in_stall(a_stall),
      .fifo_in_stall_override(a_ovr), .fifo_out(a_out), .fifo_out_valid(a_ovalid),
      .fifo_out_ack(a_ack), .fifo_clear(a_clear), .fifo_used_slots(a_used),
      .fifo_free_slots(a_free), .fifo_overflow(a_of), .fifo_underflow(a_uf),
      .fifo_err_sticky(a_sticky));

   cr_kme_stall_fifo #(.DATA_SIZE(16), .FIFO_DEPTH(5), .STALL_AT(2), .OVERRIDE_EN(1)) dut_b (
      .clk(clk), .rst(rst), .fifo_in(b_in), .fifo_in_valid(b_valid), .fifo_in_stall(b_stall),
      .fifo_in_stall_override(b_ovr), .fifo_out(b_out), .fifo_out_valid(b_ovalid),
      .fifo_out_ack(b_ack), .fifo_clear(b_clear), .fifo_used_slots(b_used),
      .fifo_free_slots(b_free), .fifo_overflow(b_of), .fifo_underflow(b_uf),
      .fifo_err_sticky(b_sticky));

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_valid", a_ovalid, 0);
      chk("rst_used", a_used, 0);
      chk("rst_free", a_free, 16);
      chk("rst_stall", a_stall, 0);
      chk("rst_sticky", a_sticky, 0);
      chk("rst_out", a_out, 0);
      chk("rst_of", a_of, 0);
      chk("rst_b_free", b_free, 5);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 1; i <= 16; i++) begin
         a_in = 132'(i);
         a_valid = 1;
         tick();
         chk("fill_used", a_used, 132'(i));
         chk("fill_head", a_out, 1);
         chk("fill_stall", a_stall, 132'(i == 16));
      end
      a_in = 132'h11; a_ack = 1;
      tick();
      chk("full_pp_used", a_used, 16);
      chk("full_pp_of", a_of, 0);
      chk("full_pp_head", a_out, 2);
      a_ack = 0; a_in = 132'h99;
      tick();
      chk("drop_of", a_of, 1);
      chk("drop_sticky", a_sticky, 2'b01);
      chk("drop_used", a_used, 16);
      a_valid = 0;
      tick();
      chk("drop_of_end", a_of, 0);
      chk("drop_sticky_hold", a_sticky, 2'b01);

      for (int k = 2; k <= 17; k++) begin
         chk("drain_head", a_out, k == 17 ? 132'h11 : 132'(k));
         a_ack = 1;
         tick();
      end
      a_ack = 0;
      chk("drain_used", a_used, 0);
      chk("drain_valid", a_ovalid, 0);
      chk("drain_uf", a_uf, 0);
      a_clear = 1;
      tick();
      a_clear = 0;
      chk("clr_sticky", a_sticky, 0);

      a_ack = 1;
      tick();
      a_ack = 0;
      chk("unf_pulse", a_uf, 1);
      chk("unf_sticky", a_sticky, 2'b10);
      chk("unf_used", a_used, 0);
      tick();
      chk("unf_end", a_uf, 0);
      chk("unf_sticky_hold", a_sticky, 2'b10);

      a_in = 132'h55; a_valid = 1; a_ack = 1;
      tick();
      a_valid = 0; a_ack = 0;
      chk("epa_used", a_used, 1);
      chk("epa_uf", a_uf, 1);
      chk("epa_head", a_out, 132'h55);

      for (int i = 0; i < 6; i++) begin
         a_in = 132'(32 + i); a_valid = 1;
         tick();
      end
      a_valid = 0;
      chk("seven_used", a_used, 7);
      a_clear = 1; a_valid = 1; a_ack = 1; a_in = 132'h77;
      tick();
      a_clear = 0; a_valid = 0; a_ack = 0;
      chk("clr_used", a_used, 0);
      chk("clr_valid", a_ovalid, 0);
      chk("clr_of", a_of, 0);
      chk("clr_uf", a_uf, 0);
      chk("clr_sticky2", a_sticky, 0);
      chk("clr_free", a_free, 16);

      for (int k = 1; k <= 3; k++) begin
         b_in = 16'(16'h100 + k); b_valid = 1;
         q.push_back(16'(16'h100 + k));
         tick();
         chk("b_used", b_used, 132'(k));
         chk("b_stall", b_stall, 132'(k >= 3));
      end
      b_valid = 0;
      b_ovr = 1;
      #1;
      chk("b_ovr_low", b_stall, 0);
      b_ovr = 0;
      #1;
      chk("b_ovr_release", b_stall, 1);
      for (int j = 0; j < 12; j++) begin
         chk("b_wrap_head", b_out, 132'(q[0]));
         b_in = 16'(16'h200 + j); b_valid = 1; b_ack = 1;
         tick();
         void'(q.pop_front());
         q.push_back(16'(16'h200 + j));
         chk("b_wrap_used", b_used, 3);
      end
      b_valid = 0; b_ack = 0;
      chk("b_wrap_final", b_out, 132'(q[0]));
      chk("b_sticky", b_sticky, 0);

      a_in = 132'hA; a_valid = 1; a_ack = 1;
      tick();
      tick();
      a_ack = 0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_used", a_used, 0);
      chk("mid_rst_valid", a_ovalid, 0);
      chk("mid_rst_free", a_free, 16);
      chk("mid_rst_out", a_out, 0);
      chk("mid_rst_b_used", b_used, 0);
      chk("mid_rst_stall", a_stall, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
